push_button_service_master: RTL and testbench

PUSH_BUTTON_SERVICE_MASTER -- requirements
Module: push_button_service_master

---
 rtl/push_button_service_master.sv | 152 +++++++++++++++
 tb/tb_push_button_service_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/push_button_service_master.sv
// Avalon-MM master that services a 4-bit push-button PIO: it arms the interrupt mask,
// then reads and clears the edge-capture register on irq and counts events per button.
module push_button_service_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [3:0]  IRQ_MASK  = 4'hF,
    parameter int          CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               irq,
    output logic [31:0]        avm_address,
    output logic               avm_read,
    output logic               avm_write,
    output logic [31:0]        avm_writedata,
    input  logic [31:0]        avm_readdata,
    input  logic               avm_waitrequest,
    output logic [4*CNT_W-1:0] event_counts,
    output logic [3:0]         last_events,
    output logic               event_strobe,
    output logic               busy
);

    localparam logic [31:0]      ADDR_MASK = BASE_ADDR + 32'd8;
    localparam logic [31:0]      ADDR_EC   = BASE_ADDR + 32'd12;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        INIT_MASK,
        IDLE,
        READ_EC,
        CLEAR_EC,
        UPDATE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  capture;
    logic [3:0]  capture_next;
    logic        read_next;
    logic        write_next;
    logic [31:0] address_next;
    logic [31:0] writedata_next;
    logic        busy_next;
    logic        strobe_next;

    always_comb begin
        state_next   = state;
        capture_next = capture;

        case (state)
            INIT_MASK: begin
                if (!avm_waitrequest) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (irq) begin
                    state_next = READ_EC;
                end
            end
            READ_EC: begin
                if (!avm_waitrequest) begin
                    capture_next = avm_readdata[3:0];
                    // A zero capture is a spurious interrupt: nothing to clear or count.
                    state_next   = (avm_readdata[3:0] != 4'b0000) ? CLEAR_EC : IDLE;
                end
            end
            CLEAR_EC: begin
                if (!avm_waitrequest) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = INIT_MASK;
            end
        endcase
    end

    // Bus outputs are decoded from the next state so the registered copies line up
    // with the state register cycle for cycle.
    always_comb begin
        read_next      = 1'b0;
        write_next     = 1'b0;
        address_next   = 32'h0;
        writedata_next = 32'h0;

        case (state_next)
            INIT_MASK: begin
                write_next     = 1'b1;
                address_next   = ADDR_MASK;
                writedata_next = {28'b0, IRQ_MASK};
            end
            READ_EC: begin
                read_next    = 1'b1;
                address_next = ADDR_EC;
            end
            CLEAR_EC: begin
                write_next     = 1'b1;
                address_next   = ADDR_EC;
                writedata_next = {28'b0, capture_next};
            end
            default: begin
                read_next = 1'b0;
            end
        endcase

        busy_next   = (state_next != IDLE);
        strobe_next = (state_next == UPDATE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INIT_MASK;
            capture       <= 4'b0000;
            avm_read      <= 1'b0;
            avm_write     <= 1'b1;
            avm_address   <= ADDR_MASK;
            avm_writedata <= {28'b0, IRQ_MASK};
            busy          <= 1'b1;
            event_strobe  <= 1'b0;
        end else begin
            state         <= state_next;
            capture       <= capture_next;
            avm_read      <= read_next;
            avm_write     <= write_next;
            avm_address   <= address_next;
            avm_writedata <= writedata_next;
            busy          <= busy_next;
            event_strobe  <= strobe_next;
        end
    end

    // Counters and last_events change on the edge entering UPDATE, so they become
    // visible in the same cycle as event_strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_counts <= '0;
            last_events  <= 4'b0000;
        end else if (state == CLEAR_EC && state_next == UPDATE) begin
            last_events <= capture;
            for (int n = 0; n < 4; n++) begin
                if (capture[n]) begin
                    event_counts[n*CNT_W +: CNT_W] <= event_counts[n*CNT_W +: CNT_W] + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_push_button_service_master.sv
// Directed bench for push_button_service_master: init write, services, stalls,
// spurious irq, counter wrap and reset in the middle of a clear.
module tb_push_button_service_master;

    logic        clk;
    logic        reset_n;
    logic        irq;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] event_counts;
    logic [3:0]  last_events;
    logic        event_strobe;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    logic [31:0] last_rd_addr = 32'h0;

    push_button_service_master #(
        .BASE_ADDR(32'h0000_0000),
        .IRQ_MASK (4'hF),
        .CNT_W    (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .irq            (irq),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .event_counts   (event_counts),
        .last_events    (last_events),
        .event_strobe   (event_strobe),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted-transfer monitor.
    always @(posedge clk) begin
        if (reset_n && !avm_waitrequest) begin
            if (avm_read) begin
                rd_cnt       <= rd_cnt + 1;
                last_rd_addr <= avm_address;
            end
            if (avm_write) begin
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= avm_address;
                last_wr_data <= avm_writedata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n         = 1'b1;
        irq             = 1'b0;
        avm_readdata    = 32'h0;
        avm_waitrequest = 1'b0;

        // Reset: the INIT_MASK write is presented while reset is still low.
        #1 reset_n = 1'b0;
        #2;
        check("rst_busy", busy, 1);
        check("rst_write", avm_write, 1);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 32'h8);
        check("rst_wdata", avm_writedata, 32'hF);
        check("rst_strobe", event_strobe, 0);
        check("rst_counts", event_counts, 32'h0);
        check("rst_last", last_events, 0);
        tick();
        tick();
        reset_n = 1'b1;

        // Mask write accepted on the first edge, then idle.
        tick();
        check("init_wr_cnt", wr_cnt, 1);
        check("init_wr_addr", last_wr_addr, 32'h8);
        check("init_wr_data", last_wr_data, 32'hF);
        check("init_busy", busy, 0);
        check("init_write_off", avm_write, 0);
        check("idle_addr_zero", avm_address, 32'h0);
        check("idle_wdata_zero", avm_writedata, 32'h0);
        tick();
        check("idle_stays", busy, 0);
        check("idle_wr_cnt", wr_cnt, 1);

        // Service with capture 0x5.
        irq          = 1'b1;
        avm_readdata = 32'h5;
        tick();
        check("s1_read", avm_read, 1);
        check("s1_read_addr", avm_address, 32'hC);
        check("s1_busy", busy, 1);
        tick();
        irq = 1'b0;
        check("s1_clear_write", avm_write, 1);
        check("s1_clear_read", avm_read, 0);
        check("s1_clear_addr", avm_address, 32'hC);
        check("s1_clear_data", avm_writedata, 32'h5);
        check("s1_no_strobe", event_strobe, 0);
        tick();
        check("s1_strobe", event_strobe, 1);
        check("s1_counts", event_counts, 32'h0001_0001);
        check("s1_last", last_events, 4'b0101);
        check("s1_upd_write", avm_write, 0);
        check("s1_upd_busy", busy, 1);
        tick();
        check("s1_strobe_off", event_strobe, 0);
        check("s1_idle", busy, 0);
        check("s1_rd_cnt", rd_cnt, 1);
        check("s1_wr_cnt", wr_cnt, 2);

        // Service with 3-cycle stalls on both read and clear; readdata is junk while stalled.
        irq             = 1'b1;
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hF;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("s2_read_held", avm_read, 1);
            check("s2_read_addr", avm_address, 32'hC);
            check("s2_rd_pending", rd_cnt, 1);
            tick();
        end
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h3;
        tick();
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hF;
        for (int i = 0; i < 3; i++) begin
            check("s2_write_held", avm_write, 1);
            check("s2_write_noread", avm_read, 0);
            check("s2_write_addr", avm_address, 32'hC);
            check("s2_write_data", avm_writedata, 32'h3);
            check("s2_wr_pending", wr_cnt, 2);
            tick();
        end
        avm_waitrequest = 1'b0;
        irq             = 1'b0;
        tick();
        check("s2_strobe", event_strobe, 1);
        check("s2_counts", event_counts, 32'h0001_0102);
        check("s2_last", last_events, 4'b0011);
        check("s2_rd_cnt", rd_cnt, 2);
        check("s2_wr_cnt", wr_cnt, 3);
        tick();
        check("s2_idle", busy, 0);

        // Spurious irq: zero capture returns to idle without a clear or a strobe.
        irq          = 1'b1;
        avm_readdata = 32'h0;
        tick();
        check("sp_read", avm_read, 1);
        irq = 1'b0;
        tick();
        check("sp_idle", busy, 0);
        check("sp_no_write", avm_write, 0);
        check("sp_no_strobe", event_strobe, 0);
        tick();
        check("sp_wr_cnt", wr_cnt, 3);
        check("sp_rd_cnt", rd_cnt, 3);
        check("sp_counts", event_counts, 32'h0001_0102);
        check("sp_last", last_events, 4'b0011);

        // Button 3 counter: 255 services, then one more wraps to zero.
        for (int i = 0; i < 255; i++) begin
            irq          = 1'b1;
            avm_readdata = 32'h8;
            tick();
            irq = 1'b0;
            tick();
            tick();
            tick();
        end
        check("wrap_255", event_counts, 32'hFF01_0102);
        irq          = 1'b1;
        avm_readdata = 32'h8;
        tick();
        irq = 1'b0;
        tick();
        tick();
        check("wrap_strobe", event_strobe, 1);
        check("wrap_zero", event_counts, 32'h0001_0102);
        check("wrap_last", last_events, 4'b1000);
        tick();

        // Reset during a stalled clear, with irq held through the following init.
        irq          = 1'b1;
        avm_readdata = 32'h2;
        tick();
        tick();
        avm_waitrequest = 1'b1;
        tick();
        check("mr_in_clear", avm_writedata, 32'h2);
        #2 reset_n = 1'b0;
        #1;
        check("mr_write", avm_write, 1);
        check("mr_addr", avm_address, 32'h8);
        check("mr_data", avm_writedata, 32'hF);
        check("mr_counts", event_counts, 32'h0);
        check("mr_last", last_events, 0);
        check("mr_busy", busy, 1);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("mr_init_held", avm_write, 1);
        check("mr_init_noread", avm_read, 0);
        avm_waitrequest = 1'b0;
        tick();
        check("mr_idle", busy, 0);
        tick();
        check("mr_irq_read", avm_read, 1);
        irq = 1'b0;
        tick();
        tick();
        check("mr_strobe", event_strobe, 1);
        check("mr_counts_after", event_counts, 32'h0000_0100);
        tick();
        check("mr_end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
